// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_arb_pkg
// Purpose  : Shared types and constants for the AXI4 read-channel arbiter
//            (FSM state encoding, AR sideband tie-off values, grant width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

  // Width of grant_id / round-robin pointer; covers up to 4 requesters.
  localparam int GRANT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Downstream AR sideband is not arbitrated; these are fixed values.
  localparam logic       C_ARLOCK  = 1'b0;
  localparam logic [3:0] C_ARCACHE = 4'b0011;  // bufferable + modifiable
  localparam logic [3:0] C_ARQOS   = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request found when searching upward from ptr, wrapping modulo
//            NUM_REQ.
// Ports    : req        - request vector
//            ptr        - search start index (must be < NUM_REQ)
//            gnt_onehot - one-hot winner (all zero when no request)
//            gnt_idx    - winner index
//            gnt_valid  - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [GRANT_W-1:0] gnt_idx,
  output logic               gnt_valid
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit to ptr is the
  // last assignment and therefore wins, without needing a loop break.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    w_idx      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = SEL_W'((int'(ptr) + off) % NUM_REQ);
      if (req[w_idx]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = GRANT_W'(w_idx);
        gnt_onehot = NUM_REQ'(1) << w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one downstream AXI4 read channel (AR + R) among NUM_REQ
//            upstream requesters. Round-robin grant held for a whole burst
//            (one outstanding transaction), with ARLEN vs RLAST checking.
// Ports    : aclk, areset        - clock, async active-high reset
//            S_AXI_AR*           - packed per-requester address channels
//            S_AXI_R*            - R data broadcast, RVALID one-hot
//            M_AXI_AR*, M_AXI_R* - downstream read channel
//            busy                - FSM not idle
//            grant_id            - current / most recent grant
//            len_err             - one-cycle pulse on burst-length mismatch
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                              aclk,
  input  logic                              areset,
  // upstream AR, packed per requester
  input  logic [NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [NUM_REQ*8-1:0]              S_AXI_ARLEN,
  input  logic [NUM_REQ*3-1:0]              S_AXI_ARSIZE,
  input  logic [NUM_REQ*2-1:0]              S_AXI_ARBURST,
  input  logic [NUM_REQ*3-1:0]              S_AXI_ARPROT,
  input  logic [NUM_REQ-1:0]                S_AXI_ARVALID,
  output logic [NUM_REQ-1:0]                S_AXI_ARREADY,
  // upstream R
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic [NUM_REQ-1:0]                S_AXI_RVALID,
  input  logic [NUM_REQ-1:0]                S_AXI_RREADY,
  // downstream AR
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARLOCK,
  output logic [3:0]                        M_AXI_ARCACHE,
  output logic [3:0]                        M_AXI_ARQOS,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // downstream R
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  // status
  output logic                              busy,
  output logic [GRANT_W-1:0]                grant_id,
  output logic                              len_err
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [GRANT_W-1:0]  r_rr_ptr;
  logic [GRANT_W-1:0]  r_grant_id;
  logic [NUM_REQ-1:0]  r_grant_oh;
  logic [7:0]          r_beat_cnt;
  logic                r_late_flagged;  // late-RLAST already reported this burst

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [GRANT_W-1:0]  w_pick_idx;
  logic                w_pick_valid;
  logic [SEL_W-1:0]    w_sel;
  logic                w_ar_hs;
  logic                w_r_hs;

  // Unpacked per-requester views of the packed AR buses.
  logic [AW-1:0] w_req_addr  [NUM_REQ];
  logic [7:0]    w_req_len   [NUM_REQ];
  logic [2:0]    w_req_size  [NUM_REQ];
  logic [1:0]    w_req_burst [NUM_REQ];
  logic [2:0]    w_req_prot  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_addr[gi]  = S_AXI_ARADDR[gi*AW +: AW];
    assign w_req_len[gi]   = S_AXI_ARLEN[gi*8 +: 8];
    assign w_req_size[gi]  = S_AXI_ARSIZE[gi*3 +: 3];
    assign w_req_burst[gi] = S_AXI_ARBURST[gi*2 +: 2];
    assign w_req_prot[gi]  = S_AXI_ARPROT[gi*3 +: 3];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (S_AXI_ARVALID),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_pick_oh),
    .gnt_idx    (w_pick_idx),
    .gnt_valid  (w_pick_valid)
  );

  assign w_sel         = r_grant_id[SEL_W-1:0];
  assign busy          = (r_state != IDLE);
  assign grant_id      = r_grant_id;
  assign M_AXI_ARLOCK  = C_ARLOCK;
  assign M_AXI_ARCACHE = C_ARCACHE;
  assign M_AXI_ARQOS   = C_ARQOS;

  // Next state and all channel steering. Every output is gated by state so
  // that nothing leaks onto a requester that does not own the channel.
  always_comb begin
    w_state_nxt   = r_state;
    M_AXI_ARADDR  = '0;
    M_AXI_ARLEN   = '0;
    M_AXI_ARSIZE  = '0;
    M_AXI_ARBURST = '0;
    M_AXI_ARPROT  = '0;
    M_AXI_ARVALID = 1'b0;
    S_AXI_ARREADY = '0;
    S_AXI_RVALID  = '0;
    S_AXI_RDATA   = '0;
    S_AXI_RRESP   = '0;
    S_AXI_RLAST   = 1'b0;
    M_AXI_RREADY  = 1'b0;
    len_err       = 1'b0;
    w_ar_hs       = 1'b0;
    w_r_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = ADDR;
      end
      ADDR: begin
        M_AXI_ARADDR  = w_req_addr[w_sel];
        M_AXI_ARLEN   = w_req_len[w_sel];
        M_AXI_ARSIZE  = w_req_size[w_sel];
        M_AXI_ARBURST = w_req_burst[w_sel];
        M_AXI_ARPROT  = w_req_prot[w_sel];
        M_AXI_ARVALID = S_AXI_ARVALID[w_sel];
        S_AXI_ARREADY = r_grant_oh & {NUM_REQ{M_AXI_ARREADY}};
        w_ar_hs       = S_AXI_ARVALID[w_sel] & M_AXI_ARREADY;
        if (w_ar_hs) w_state_nxt = DATA;
      end
      DATA: begin
        S_AXI_RVALID = r_grant_oh & {NUM_REQ{M_AXI_RVALID}};
        S_AXI_RDATA  = M_AXI_RDATA;
        S_AXI_RRESP  = M_AXI_RRESP;
        S_AXI_RLAST  = M_AXI_RLAST;
        M_AXI_RREADY = S_AXI_RREADY[w_sel];
        w_r_hs       = M_AXI_RVALID & S_AXI_RREADY[w_sel];
        if (w_r_hs) begin
          if (M_AXI_RLAST) begin
            // Early RLAST ends the burst anyway; the slave considers it done.
            w_state_nxt = IDLE;
            len_err     = (r_beat_cnt != 8'd0);
          end else if (r_beat_cnt == 8'd0) begin
            // Overrun: keep forwarding until RLAST, report only once.
            len_err = ~r_late_flagged;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_grant_oh     <= '0;
      r_beat_cnt     <= '0;
      r_late_flagged <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_pick_valid) begin
        r_grant_id <= w_pick_idx;
        r_grant_oh <= w_pick_oh;
      end
      if (w_ar_hs) begin
        r_beat_cnt     <= w_req_len[w_sel];
        r_late_flagged <= 1'b0;
        // Pointer moves past the winner only once its address is accepted.
        r_rr_ptr <= (r_grant_id == GRANT_W'(NUM_REQ - 1)) ? '0
                                                          : r_grant_id + GRANT_W'(1);
      end
      if (w_r_hs && !M_AXI_RLAST) begin
        if (r_beat_cnt != 8'd0) r_beat_cnt     <= r_beat_cnt - 8'd1;
        else                    r_late_flagged <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Self-checking bench for axi_rd_arbiter with three requesters.
//            A behavioural model tracks the most recent winner and rotates
//            the grant after it; burst-length errors are predicted from the
//            ARLEN+1 beat count versus the beat carrying RLAST.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 7;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // requester-side stimulus
  logic [AW-1:0]   req_addr [N];
  logic [7:0]      req_len  [N];
  logic [N-1:0]    req_valid;
  logic [N-1:0]    s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [N*3-1:0]  s_arprot;

  always_comb begin
    s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arprot = '0;
    for (int i = 0; i < N; i++) begin
      s_araddr[i*AW +: AW] = req_addr[i];
      s_arlen[i*8 +: 8]    = req_len[i];
      s_arsize[i*3 +: 3]   = 3'(i + 1);
      s_arburst[i*2 +: 2]  = 2'b01;
      s_arprot[i*3 +: 3]   = 3'(i);
    end
  end

  // DUT outputs / slave-side stimulus
  logic [N-1:0]  S_AXI_ARREADY, S_AXI_RVALID;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RLAST;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic [2:0]    M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [1:0]    M_AXI_ARBURST;
  logic          M_AXI_ARLOCK;
  logic [3:0]    M_AXI_ARCACHE, M_AXI_ARQOS;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic          busy, len_err;
  logic [1:0]    grant_id;

  axi_rd_arbiter #(
    .NUM_REQ(N), .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen), .S_AXI_ARSIZE(s_arsize),
    .S_AXI_ARBURST(s_arburst), .S_AXI_ARPROT(s_arprot),
    .S_AXI_ARVALID(req_valid), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(s_rready),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .busy(busy), .grant_id(grant_id), .len_err(len_err)
  );

  int checks = 0;
  int errors = 0;
  int m_last;  // model: most recently granted requester

  // Next winner: first requester after the last winner, wrapping around.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    m_last = N - 1;
  endtask

  // One complete burst starting in the IDLE (bubble) cycle at the current
  // negedge. RLAST is placed on beat ARLEN+1+rlast_delta (minimum beat 1).
  task automatic run_burst(input int rlast_delta, input int ar_wait, input int stall_beat,
                           input int stall_len, input bit keep, output int g_seen);
    int g, len, last_beat, exp_err;
    logic [N-1:0] oh;
    logic [DW-1:0] d;
    logic [1:0] rr;
    g = model_pick(req_valid);
    len = int'(req_len[g]);
    last_beat = len + 1 + rlast_delta;
    if (last_beat < 1) last_beat = 1;
    oh = '0;
    oh[g] = 1'b1;
    g_seen = -1;
    #1;
    checks++;
    if (busy !== 1'b0 || M_AXI_ARVALID !== 1'b0 || S_AXI_ARREADY !== '0) begin
      errors++;
      $display("FAIL bubble: busy=%b arvalid=%b arready=%b, required 0 0 0", busy, M_AXI_ARVALID, S_AXI_ARREADY);
    end
    @(negedge aclk);
    for (int w = 0; w <= ar_wait; w++) begin
      M_AXI_ARREADY = (w == ar_wait);
      #1;
      if (w == 0) g_seen = int'(grant_id);
      checks++;
      if (M_AXI_ARVALID !== 1'b1 || grant_id !== 2'(g) || busy !== 1'b1) begin
        errors++;
        $display("FAIL addr_grant: arvalid=%b grant_id=%0d busy=%b, required 1 %0d 1", M_AXI_ARVALID, grant_id, busy, g);
      end
      checks++;
      if (M_AXI_ARADDR !== req_addr[g] || M_AXI_ARLEN !== req_len[g] || M_AXI_ARSIZE !== 3'(g + 1) ||
          M_AXI_ARPROT !== 3'(g) || M_AXI_ARBURST !== 2'b01) begin
        errors++;
        $display("FAIL addr_mux: addr=%h len=%0d size=%0d prot=%0d, required %h %0d %0d %0d",
                 M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARPROT, req_addr[g], req_len[g], g + 1, g);
      end
      checks++;
      if (S_AXI_ARREADY !== ((w == ar_wait) ? oh : '0)) begin
        errors++;
        $display("FAIL addr_ready: arready=%b, required %b", S_AXI_ARREADY, (w == ar_wait) ? oh : '0);
      end
      @(negedge aclk);
    end
    M_AXI_ARREADY = 1'b0;
    m_last = g;
    if (!keep) req_valid[g] = 1'b0;
    for (int k = 1; k <= last_beat; k++) begin
      d = {$urandom, $urandom};
      rr = 2'($urandom);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = d;
      M_AXI_RRESP  = rr;
      M_AXI_RLAST  = (k == last_beat);
      if (k == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          s_rready = N'($urandom) & ~oh;
          #1;
          checks++;
          if (M_AXI_RREADY !== 1'b0 || S_AXI_RVALID !== oh || len_err !== 1'b0) begin
            errors++;
            $display("FAIL stall: rready=%b rvalid=%b len_err=%b, required 0 %b 0", M_AXI_RREADY, S_AXI_RVALID, len_err, oh);
          end
          @(negedge aclk);
        end
      end
      s_rready = N'($urandom) | oh;
      exp_err = ((k < len + 1) && (k == last_beat)) || ((k == len + 1) && (k != last_beat));
      #1;
      checks++;
      if (S_AXI_RVALID !== oh || M_AXI_RREADY !== 1'b1 || S_AXI_RDATA !== d || S_AXI_RRESP !== rr ||
          S_AXI_RLAST !== (k == last_beat)) begin
        errors++;
        $display("FAIL beat%0d: rvalid=%b rready=%b data=%h resp=%0d last=%b, required %b 1 %h %0d %b",
                 k, S_AXI_RVALID, M_AXI_RREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, oh, d, rr, k == last_beat);
      end
      checks++;
      if (len_err !== 1'(exp_err) || busy !== 1'b1 || M_AXI_ARVALID !== 1'b0 || S_AXI_ARREADY !== '0) begin
        errors++;
        $display("FAIL beat%0d_status: len_err=%b busy=%b arvalid=%b arready=%b, required %0d 1 0 0",
                 k, len_err, busy, M_AXI_ARVALID, S_AXI_ARREADY, exp_err);
      end
      @(negedge aclk);
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    s_rready     = '0;
  endtask

  task automatic test_reset();
    int g;
    areset = 1'b1;
    req_valid = '1;
    s_rready = '1;
    M_AXI_ARREADY = 1'b1;
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST = 1'b1;
    M_AXI_RDATA = '0;
    M_AXI_RRESP = '0;
    for (int i = 0; i < N; i++) begin req_addr[i] = '0; req_len[i] = '0; end
    repeat (2) @(negedge aclk);
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || len_err !== 1'b0 || M_AXI_ARVALID !== 1'b0 ||
        M_AXI_RREADY !== 1'b0 || S_AXI_ARREADY !== '0 || S_AXI_RVALID !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b gid=%0d len_err=%b arvalid=%b rready=%b arready=%b rvalid=%b, required all 0",
               busy, grant_id, len_err, M_AXI_ARVALID, M_AXI_RREADY, S_AXI_ARREADY, S_AXI_RVALID);
    end
    checks++;
    if (M_AXI_ARLOCK !== 1'b0 || M_AXI_ARCACHE !== 4'b0011 || M_AXI_ARQOS !== 4'b0000) begin
      errors++;
      $display("FAIL tieoffs: lock=%b cache=%b qos=%b, required 0 0011 0000", M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARQOS);
    end
    req_valid = '0; s_rready = '0; M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    m_last = N - 1;
    g = 0;
  endtask

  task automatic test_single();
    int g;
    @(negedge aclk);
    req_addr[0] = 7'h10;
    req_len[0] = 8'd3;
    req_valid = 3'b001;
    run_burst(0, 0, 0, 0, 1'b0, g);
    #1;
    checks++;
    if (busy !== 1'b0 || g !== 0) begin
      errors++;
      $display("FAIL single_end: busy=%b grant=%0d, required 0 0", busy, g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_order [4] = '{0, 1, 0, 1};
    do_reset();
    req_len[0] = 8'd0; req_len[1] = 8'd0;
    req_addr[0] = 7'h21; req_addr[1] = 7'h42;
    req_valid = 3'b011;
    for (int b = 0; b < 4; b++) begin
      run_burst(0, 0, 0, 0, 1'b1, g);
      checks++;
      if (g !== exp_order[b]) begin
        errors++;
        $display("FAIL rr_order[%0d]: grant=%0d, required %0d", b, g, exp_order[b]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_early_rlast();
    int g;
    @(negedge aclk);
    req_len[1] = 8'd3;
    req_valid = 3'b010;
    run_burst(-2, 1, 0, 0, 1'b0, g);
    req_len[0] = 8'd1;
    req_valid = 3'b011;
    run_burst(0, 0, 0, 0, 1'b0, g);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL early_next_grant: grant=%0d, required 0", g);
    end
    req_valid = '0;
  endtask

  task automatic test_late_rlast();
    int g;
    @(negedge aclk);
    req_len[2] = 8'd1;
    req_valid = 3'b100;
    run_burst(1, 0, 0, 0, 1'b0, g);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL late_release: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_rready_stall();
    int g;
    @(negedge aclk);
    req_len[0] = 8'd3;
    req_valid = 3'b001;
    run_burst(0, 0, 2, 5, 1'b0, g);
  endtask

  task automatic test_reset_mid_burst();
    int g;
    @(negedge aclk);
    req_len[1] = 8'd3;
    req_valid = 3'b010;
    @(negedge aclk);
    M_AXI_ARREADY = 1'b1;
    @(negedge aclk);
    M_AXI_ARREADY = 1'b0;
    req_valid = '0;
    M_AXI_RVALID = 1'b1;
    M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = {$urandom, $urandom};
    s_rready = '1;
    @(negedge aclk);
    #1;
    checks++;
    if (busy !== 1'b1 || S_AXI_RVALID !== 3'b010) begin
      errors++;
      $display("FAIL pre_reset: busy=%b rvalid=%b, required 1 010", busy, S_AXI_RVALID);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || S_AXI_RVALID !== '0 || M_AXI_RREADY !== 1'b0 || grant_id !== 2'd0 ||
        len_err !== 1'b0 || S_AXI_RLAST !== 1'b0 || M_AXI_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b rvalid=%b rready=%b gid=%0d len_err=%b rlast=%b arvalid=%b, required all 0",
               busy, S_AXI_RVALID, M_AXI_RREADY, grant_id, len_err, S_AXI_RLAST, M_AXI_ARVALID);
    end
    @(negedge aclk);
    areset = 1'b0;
    M_AXI_RVALID = 1'b0;
    s_rready = '0;
    m_last = N - 1;
    req_len[1] = 8'd0; req_len[2] = 8'd0;
    req_valid = 3'b110;
    run_burst(0, 0, 0, 0, 1'b0, g);
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL post_reset_ptr: grant=%0d, required 1", g);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, delta, stall;
    @(negedge aclk);
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_addr[i] = AW'($urandom);
          req_len[i]  = 8'($urandom_range(0, 7));
        end
      end
      req_valid = req_valid | N'($urandom);
      if (req_valid == '0) req_valid[$urandom_range(0, N - 1)] = 1'b1;
      case ($urandom_range(0, 5))
        0:       delta = -1;
        4:       delta = 1;
        5:       delta = 2;
        default: delta = 0;
      endcase
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_burst(delta, $urandom_range(0, 2), 1, stall, 1'b0, g);
    end
    req_valid = '0;
  endtask

  initial begin
    m_last = N - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_early_rlast();
    test_late_rlast();
    test_rready_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
